// File: rtl/sensor_conditioner.sv
// sensor_conditioner
//   Front end of the smart-home controller. It cleans up the raw house sensors
//   before the controller FSM sees them.
//   - Four contact inputs (front door, rear door, window, fire alarm) are each
//     passed through a SYNC_STAGES-deep synchroniser and then a debounce
//     counter. The fire alarm uses a shorter debounce window.
//   - 7-bit temperature samples are box-car averaged over 2**AVG_LOG2 strobes.
//
// Ports
//   clk        in   1  single clock, rising edge
//   Rst        in   1  synchronous active-low reset
//   raw_SFD    in   1  front-door contact (asynchronous)
//   raw_SRD    in   1  rear-door contact (asynchronous)
//   raw_SW     in   1  window contact (asynchronous)
//   raw_SFA    in   1  fire-alarm contact (asynchronous)
//   raw_ST     in   7  temperature sample, valid with temp_valid
//   temp_valid in   1  one-cycle strobe marking a new raw_ST sample
//   SFD        out  1  debounced front door
//   SRD        out  1  debounced rear door
//   SW         out  1  debounced window
//   SFA        out  1  debounced fire alarm
//   ST         out  7  averaged temperature (registered)
//   st_upd     out  1  one-cycle pulse aligned with a new ST value
module sensor_conditioner #(
  parameter int         SYNC_STAGES = 2,
  parameter int         DB_CYCLES   = 8,
  parameter int         FIRE_CYCLES = 2,
  parameter int         AVG_LOG2    = 2,
  parameter logic [6:0] ST_RESET    = 7'd25
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       raw_SFD,
  input  logic       raw_SRD,
  input  logic       raw_SW,
  input  logic       raw_SFA,
  input  logic [6:0] raw_ST,
  input  logic       temp_valid,
  output logic       SFD,
  output logic       SRD,
  output logic       SW,
  output logic       SFA,
  output logic [6:0] ST,
  output logic       st_upd
);

  // Channel order: 0 = front door, 1 = rear door, 2 = window, 3 = fire alarm.
  logic [3:0] w_raw;
  logic [3:0] w_db;

  assign w_raw = {raw_SFA, raw_SW, raw_SRD, raw_SFD};

  for (genvar g = 0; g < 4; g++) begin : g_ch
    // Fire alarm takes the fast debounce window so it reaches the controller sooner.
    localparam int N  = (g == 3) ? FIRE_CYCLES : DB_CYCLES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LIM = CW'(N - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_q;
    logic                   w_s;

    assign w_s   = r_sync[SYNC_STAGES-1];
    assign w_db[g] = r_q;

    // Synchroniser shift chain plus debounce counter; the output only flips
    // after the synchronised level has differed from it for N straight cycles.
    always_ff @(posedge clk) begin
      if (!Rst) begin
        r_sync <= '0;
        r_cnt  <= '0;
        r_q    <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
        if (w_s == r_q) begin
          r_cnt <= '0;
        end else if (r_cnt == LIM) begin
          r_q   <= w_s;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign SFD = w_db[0];
  assign SRD = w_db[1];
  assign SW  = w_db[2];
  assign SFA = w_db[3];

  // Temperature averaging. With AVG_LOG2 = 0 the sample counter is a single
  // bit pinned at zero, so every strobe is the final one.
  localparam int ACCW = 7 + AVG_LOG2;
  localparam int CNTW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'((1 << AVG_LOG2) - 1);

  logic [ACCW-1:0] r_acc;
  logic [CNTW-1:0] r_cnt_s;
  logic [6:0]      r_st;
  logic            r_upd;
  logic [ACCW-1:0] w_sum;
  logic            w_last;

  // The accumulator width holds 127 * 2**AVG_LOG2, so the sum never wraps.
  assign w_sum  = r_acc + ACCW'(raw_ST);
  assign w_last = (r_cnt_s == CNT_MAX);

  // Accumulate strobed samples; on the last one publish the truncated mean.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      r_acc   <= '0;
      r_cnt_s <= '0;
      r_st    <= ST_RESET;
      r_upd   <= 1'b0;
    end else if (temp_valid) begin
      if (w_last) begin
        r_st    <= 7'(w_sum >> AVG_LOG2);
        r_acc   <= '0;
        r_cnt_s <= '0;
        r_upd   <= 1'b1;
      end else begin
        r_acc   <= w_sum;
        r_cnt_s <= r_cnt_s + CNTW'(1);
        r_upd   <= 1'b0;
      end
    end else begin
      r_upd <= 1'b0;
    end
  end

  assign ST     = r_st;
  assign st_upd = r_upd;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with default parameters.
module tb_sensor_conditioner;

  logic       clk;
  logic       Rst;
  logic       raw_SFD;
  logic       raw_SRD;
  logic       raw_SW;
  logic       raw_SFA;
  logic [6:0] raw_ST;
  logic       temp_valid;
  logic       SFD;
  logic       SRD;
  logic       SW;
  logic       SFA;
  logic [6:0] ST;
  logic       st_upd;

  int n_cmp = 0;
  int n_err = 0;

  sensor_conditioner dut (
    .clk        (clk),
    .Rst        (Rst),
    .raw_SFD    (raw_SFD),
    .raw_SRD    (raw_SRD),
    .raw_SW     (raw_SW),
    .raw_SFA    (raw_SFA),
    .raw_ST     (raw_ST),
    .temp_valid (temp_valid),
    .SFD        (SFD),
    .SRD        (SRD),
    .SW         (SW),
    .SFA        (SFA),
    .ST         (ST),
    .st_upd     (st_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Feed the four samples back-to-back, one strobe per cycle.
  task automatic strobe4(input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c, input logic [6:0] d);
    temp_valid = 1'b1;
    raw_ST = a; tick(1);
    raw_ST = b; tick(1);
    raw_ST = c; tick(1);
    raw_ST = d; tick(1);
    temp_valid = 1'b0;
    raw_ST = 7'd0;
  endtask

  initial begin
    Rst = 1'b0;
    raw_SFD = 1'b1; raw_SRD = 1'b1; raw_SW = 1'b1; raw_SFA = 1'b1;
    raw_ST = 7'd99; temp_valid = 1'b1;

    // 1. Reset held for three edges with all raw inputs high
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_contacts", {28'd0, SFD, SRD, SW, SFA}, 32'd0);
      chk("rst_st", {25'd0, ST}, 32'd25);
      chk("rst_upd", {31'd0, st_upd}, 32'd0);
    end

    Rst = 1'b1;
    raw_SFD = 1'b0; raw_SRD = 1'b0; raw_SW = 1'b0; raw_SFA = 1'b0;
    temp_valid = 1'b0; raw_ST = 7'd0;
    tick(12);
    chk("idle_contacts", {28'd0, SFD, SRD, SW, SFA}, 32'd0);
    chk("idle_st", {25'd0, ST}, 32'd25);

    // Single-cycle glitch on the fire alarm is shorter than its window
    raw_SFA = 1'b1; tick(1); raw_SFA = 1'b0;
    tick(8);
    chk("sfa_glitch", {31'd0, SFA}, 32'd0);

    // 2. Front-door step: output flips on edge 10
    raw_SFD = 1'b1;
    tick(9);
    chk("sfd_edge9", {31'd0, SFD}, 32'd0);
    tick(1);
    chk("sfd_edge10", {31'd0, SFD}, 32'd1);

    // Fire-alarm step: output flips on edge 4
    raw_SFA = 1'b1;
    tick(3);
    chk("sfa_edge3", {31'd0, SFA}, 32'd0);
    tick(1);
    chk("sfa_edge4", {31'd0, SFA}, 32'd1);
    raw_SFD = 1'b0; raw_SFA = 1'b0;
    tick(14);
    chk("sfd_sfa_fall", {30'd0, SFD, SFA}, 32'd0);

    // 3. Window pulse of 5 cycles is filtered out
    raw_SW = 1'b1; tick(5); raw_SW = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("sw_short", {31'd0, SW}, 32'd0);
    end

    // Window high for 9 cycles: rises on edge 10, falls 10 edges after the drop
    raw_SW = 1'b1;
    tick(9);
    chk("sw_long_e9", {31'd0, SW}, 32'd0);
    raw_SW = 1'b0;
    tick(1);
    chk("sw_long_e10", {31'd0, SW}, 32'd1);
    tick(8);
    chk("sw_drop9", {31'd0, SW}, 32'd1);
    tick(1);
    chk("sw_drop10", {31'd0, SW}, 32'd0);

    // 4. Average of 20,21,22,24 = 87>>2 = 21
    temp_valid = 1'b1;
    raw_ST = 7'd20; tick(1);
    raw_ST = 7'd21; tick(1);
    raw_ST = 7'd22; tick(1);
    chk("avg_pre_upd", {31'd0, st_upd}, 32'd0);
    chk("avg_pre_st", {25'd0, ST}, 32'd25);
    raw_ST = 7'd24; tick(1);
    temp_valid = 1'b0; raw_ST = 7'd100;
    chk("avg_st", {25'd0, ST}, 32'd21);
    chk("avg_upd", {31'd0, st_upd}, 32'd1);
    tick(1);
    chk("avg_upd_clear", {31'd0, st_upd}, 32'd0);
    chk("avg_st_hold", {25'd0, ST}, 32'd21);
    // raw_ST changes without a strobe are ignored
    tick(3);
    chk("avg_no_strobe", {25'd0, ST}, 32'd21);

    // 5. Full-scale samples do not overflow
    strobe4(7'd127, 7'd127, 7'd127, 7'd127);
    chk("max_st", {25'd0, ST}, 32'd127);
    chk("max_upd", {31'd0, st_upd}, 32'd1);

    // Partial average discarded by reset
    temp_valid = 1'b1;
    raw_ST = 7'd30; tick(1);
    raw_ST = 7'd30; tick(1);
    temp_valid = 1'b0;
    Rst = 1'b0;
    tick(1);
    chk("part_rst_st", {25'd0, ST}, 32'd25);
    chk("part_rst_upd", {31'd0, st_upd}, 32'd0);
    Rst = 1'b1;
    strobe4(7'd40, 7'd40, 7'd40, 7'd40);
    chk("after_rst_st", {25'd0, ST}, 32'd40);
    chk("after_rst_upd", {31'd0, st_upd}, 32'd1);
    tick(2);

    // 6. Simultaneous steps on three channels
    raw_SFD = 1'b1; raw_SRD = 1'b1; raw_SFA = 1'b1;
    tick(3);
    chk("multi_e3", {28'd0, SFD, SRD, SW, SFA}, 32'd0);
    tick(1);
    chk("multi_e4", {28'd0, SFD, SRD, SW, SFA}, 32'd1);
    tick(5);
    chk("multi_e9", {28'd0, SFD, SRD, SW, SFA}, 32'd1);
    tick(1);
    chk("multi_e10", {28'd0, SFD, SRD, SW, SFA}, 32'b1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
